// File: rtl/core_pkg.sv
// Shared core definitions: default data/address widths and the
// write-port arbiter state encoding.
package core_pkg;

    localparam int CORE_XLEN   = 32;
    localparam int CORE_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // holding FIFO empty
        PEND   = 2'd1,  // LU results queued, waiting for a free port slot
        STARVE = 2'd2   // pipeline stalled so the FIFO head can retire
    } arb_state_e;

endpackage

// File: rtl/wb_lu_fifo.sv
// Parameterised synchronous FIFO holding LU results ({addr, data}).
// Ports:
//   clk, rst_n      clock / async active-low reset
//   push_i, wdata_i enqueue request and data (ignored when full)
//   pop_i           dequeue request (ignored when empty)
//   rdata_o         head entry (valid when !empty_o)
//   full_o, empty_o occupancy flags
//   count_o         current occupancy
module wb_lu_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage
// (priority) and a long-latency unit whose results queue in a small FIFO.
// A starvation FSM raises stall_req so a repeatedly blocked FIFO head retires.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   wb_we, wb_addr, wb_data        WB stage write request
//   lu_valid, lu_ready             LU handshake (transfer on valid & ready)
//   lu_addr, lu_data               LU result
//   rf_we, rf_addr, rf_data        registered register-file write port
//   stall_req                      freeze pipeline while high
//   q_count                        FIFO occupancy
module wb_write_arbiter
    import core_pkg::*;
#(
    parameter int XLEN       = CORE_XLEN,
    parameter int ADDR_W     = CORE_ADDR_W,
    parameter int QDEPTH     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_we,
    input  logic [ADDR_W-1:0]           wb_addr,
    input  logic [XLEN-1:0]             wb_data,
    input  logic                        lu_valid,
    output logic                        lu_ready,
    input  logic [ADDR_W-1:0]           lu_addr,
    input  logic [XLEN-1:0]             lu_data,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_addr,
    output logic [XLEN-1:0]             rf_data,
    output logic                        stall_req,
    output logic [$clog2(QDEPTH+1)-1:0] q_count
);

    localparam int CNT_W = $clog2(QDEPTH+1);
    localparam int SC_W  = $clog2(STARVE_MAX+1);

    arb_state_e           state_q, state_d;
    logic [SC_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                 rf_we_q;
    logic [ADDR_W-1:0]    rf_addr_q;
    logic [XLEN-1:0]      rf_data_q;

    logic                 push, pop, full, empty;
    logic [ADDR_W+XLEN-1:0] head;
    logic [ADDR_W-1:0]    head_addr;
    logic [XLEN-1:0]      head_data;
    logic                 wb_ok, sel_wb, blk, last_out;
    logic                 grant_we;
    logic [ADDR_W-1:0]    grant_addr;
    logic [XLEN-1:0]      grant_data;

    assign lu_ready  = !full;
    assign push      = lu_valid && lu_ready;
    assign head_addr = head[XLEN +: ADDR_W];
    assign head_data = head[XLEN-1:0];
    assign stall_req = (state_q == STARVE);

    wb_lu_fifo #(.W(ADDR_W+XLEN), .DEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({lu_addr, lu_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (q_count)
    );

    // Writes to x0 never occupy the port; in STARVE the head owns the port.
    assign wb_ok    = wb_we && (wb_addr != '0);
    assign sel_wb   = wb_ok && (state_q != STARVE);
    assign pop      = !sel_wb && !empty;
    assign blk      = (state_q == PEND) && !empty && wb_ok;
    assign last_out = (q_count == CNT_W'(1)) && !push;

    always_comb begin
        grant_we   = 1'b0;
        grant_addr = wb_addr;
        grant_data = wb_data;
        if (sel_wb) begin
            grant_we = 1'b1;
        end else if (pop) begin
            // x0 entries are consumed without a register-file write.
            grant_we   = (head_addr != '0);
            grant_addr = head_addr;
            grant_data = head_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                starve_cnt_d = '0;
                if (push) state_d = PEND;
            end
            PEND: begin
                if (pop) begin
                    starve_cnt_d = '0;
                    if (last_out) state_d = IDLE;
                end else if (blk) begin
                    if (starve_cnt_q == SC_W'(STARVE_MAX-1)) begin
                        state_d      = STARVE;
                        starve_cnt_d = '0;
                    end else begin
                        starve_cnt_d = starve_cnt_q + SC_W'(1);
                    end
                end
            end
            STARVE: begin
                starve_cnt_d = '0;
                state_d      = last_out ? IDLE : PEND;
            end
            default: begin
                state_d      = IDLE;
                starve_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= grant_we;
            if (grant_we) begin
                rf_addr_q <= grant_addr;
                rf_data_q <= grant_data;
            end
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [31:0] wb_addr, wb_data;
    logic        lu_valid, lu_ready;
    logic [31:0] lu_addr, lu_data;
    logic        rf_we;
    logic [31:0] rf_addr, rf_data;
    logic        stall_req;
    logic [1:0]  q_count;

    int vec  = 0;
    int miss = 0;

    wb_write_arbiter #(.XLEN(32), .ADDR_W(32), .QDEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .stall_req(stall_req), .q_count(q_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_addr = 0; wb_data = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        vec++; if ({rf_we, rf_addr, rf_data} !== 65'd0) begin miss++; $display("FAIL reset_rf got %0b/%h/%h exp 0/0/0", rf_we, rf_addr, rf_data); end
        vec++; if ({lu_ready, stall_req, q_count} !== 4'b1000) begin miss++; $display("FAIL reset_ctl got rdy=%0b stall=%0b cnt=%0d exp 1/0/0", lu_ready, stall_req, q_count); end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_wb_only();
        wb_we = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF;
        tick();
        vec++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 32'd5, 32'hDEAD_BEEF}) begin miss++; $display("FAIL wb_only got %0b/%h/%h exp 1/5/deadbeef", rf_we, rf_addr, rf_data); end
        wb_addr = 0;
        tick();
        vec++; if (rf_we !== 1'b0) begin miss++; $display("FAIL wb_addr0 rf_we got %0b exp 0", rf_we); end
        idle_inputs();
        tick();
    endtask

    task automatic test_lu_idle();
        lu_valid = 1; lu_addr = 7; lu_data = 32'h1234;
        #1;
        vec++; if (lu_ready !== 1'b1) begin miss++; $display("FAIL lu_idle_ready got %0b exp 1", lu_ready); end
        tick();
        lu_valid = 0;
        vec++; if ({rf_we, q_count} !== 3'b0_01) begin miss++; $display("FAIL lu_idle_accept got we=%0b cnt=%0d exp 0/1", rf_we, q_count); end
        tick();
        vec++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 32'd7, 32'h1234}) begin miss++; $display("FAIL lu_idle_write got %0b/%h/%h exp 1/7/1234", rf_we, rf_addr, rf_data); end
        vec++; if (q_count !== 2'd0) begin miss++; $display("FAIL lu_idle_drain got %0d exp 0", q_count); end
    endtask

    task automatic test_full();
        wb_we = 1; wb_addr = 4; wb_data = 32'hA;
        lu_valid = 1; lu_addr = 11; lu_data = 32'h11;
        tick();
        vec++; if ({rf_we, rf_addr, q_count} !== {1'b1, 32'd4, 2'd1}) begin miss++; $display("FAIL full_wb1 got %0b/%h cnt=%0d exp 1/4/1", rf_we, rf_addr, q_count); end
        lu_addr = 12; lu_data = 32'h12;
        tick();
        vec++; if ({q_count, lu_ready} !== 3'b10_0) begin miss++; $display("FAIL full_flags got cnt=%0d rdy=%0b exp 2/0", q_count, lu_ready); end
        lu_addr = 13; lu_data = 32'h13;
        tick();
        vec++; if ({q_count, lu_ready, rf_addr} !== {2'd2, 1'b0, 32'd4}) begin miss++; $display("FAIL full_hold got cnt=%0d rdy=%0b addr=%h exp 2/0/4", q_count, lu_ready, rf_addr); end
        wb_we = 0;
        tick();
        vec++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 32'd11, 32'h11}) begin miss++; $display("FAIL full_drain got %0b/%h/%h exp 1/b/11", rf_we, rf_addr, rf_data); end
        vec++; if ({q_count, lu_ready} !== 3'b01_1) begin miss++; $display("FAIL full_after got cnt=%0d rdy=%0b exp 1/1", q_count, lu_ready); end
        tick();
        lu_valid = 0;
        vec++; if ({rf_we, rf_addr, q_count} !== {1'b1, 32'd12, 2'd1}) begin miss++; $display("FAIL full_second got %0b/%h cnt=%0d exp 1/c/1", rf_we, rf_addr, q_count); end
        tick();
        vec++; if ({rf_we, rf_addr, rf_data, q_count} !== {1'b1, 32'd13, 32'h13, 2'd0}) begin miss++; $display("FAIL full_held_lu got %0b/%h/%h cnt=%0d exp 1/d/13/0", rf_we, rf_addr, rf_data, q_count); end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        wb_we = 1; wb_addr = 6; wb_data = 32'h66;
        lu_valid = 1; lu_addr = 8; lu_data = 32'h88;
        tick();
        lu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            vec++; if ({stall_req, rf_we, rf_addr} !== {1'b0, 1'b1, 32'd6}) begin miss++; $display("FAIL starve_pre%0d got stall=%0b we=%0b addr=%h exp 0/1/6", i, stall_req, rf_we, rf_addr); end
            tick();
        end
        vec++; if ({stall_req, q_count} !== 3'b1_01) begin miss++; $display("FAIL starve_raise got stall=%0b cnt=%0d exp 1/1", stall_req, q_count); end
        tick();
        vec++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 32'd8, 32'h88}) begin miss++; $display("FAIL starve_lu got %0b/%h/%h exp 1/8/88", rf_we, rf_addr, rf_data); end
        vec++; if ({stall_req, q_count} !== 3'b0_00) begin miss++; $display("FAIL starve_fall got stall=%0b cnt=%0d exp 0/0", stall_req, q_count); end
        tick();
        vec++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 32'd6, 32'h66}) begin miss++; $display("FAIL starve_wb got %0b/%h/%h exp 1/6/66", rf_we, rf_addr, rf_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        lu_valid = 1; lu_addr = 20; lu_data = 32'hA0;
        tick();
        vec++; if (q_count !== 2'd1) begin miss++; $display("FAIL b2b_first got cnt=%0d exp 1", q_count); end
        for (int i = 1; i <= 3; i++) begin
            lu_addr = 32'(20 + i); lu_data = 32'(32'hA0 + i);
            tick();
            exp_addr = 32'(20 + i - 1);
            vec++; if ({rf_we, rf_addr, rf_data, q_count} !== {1'b1, exp_addr, 32'hA0 + 32'(i - 1), 2'd1}) begin miss++; $display("FAIL b2b_%0d got %0b/%h/%h cnt=%0d exp 1/%h/%h/1", i, rf_we, rf_addr, rf_data, q_count, exp_addr, 32'hA0 + 32'(i - 1)); end
        end
        lu_valid = 0;
        tick();
        vec++; if ({rf_we, rf_addr, rf_data, q_count} !== {1'b1, 32'd23, 32'hA3, 2'd0}) begin miss++; $display("FAIL b2b_last got %0b/%h/%h cnt=%0d exp 1/17/a3/0", rf_we, rf_addr, rf_data, q_count); end
        // x0 LU entry is accepted then silently dropped.
        lu_valid = 1; lu_addr = 0; lu_data = 32'hBAD;
        tick();
        lu_valid = 0;
        vec++; if (q_count !== 2'd1) begin miss++; $display("FAIL lu_x0_accept got cnt=%0d exp 1", q_count); end
        tick();
        vec++; if ({rf_we, q_count} !== 3'b0_00) begin miss++; $display("FAIL lu_x0_drop got we=%0b cnt=%0d exp 0/0", rf_we, q_count); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midstream();
        wb_we = 1; wb_addr = 3; wb_data = 32'h33;
        lu_valid = 1; lu_addr = 9; lu_data = 32'h99;
        tick();
        lu_addr = 10; lu_data = 32'hAA;
        tick();
        vec++; if (q_count !== 2'd2) begin miss++; $display("FAIL rst_mid_setup got cnt=%0d exp 2", q_count); end
        rst_n = 0;
        #1;
        vec++; if ({rf_we, q_count, lu_ready, stall_req} !== 5'b0_00_1_0) begin miss++; $display("FAIL rst_mid got we=%0b cnt=%0d rdy=%0b stall=%0b exp 0/0/1/0", rf_we, q_count, lu_ready, stall_req); end
        idle_inputs();
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++; if ({rf_we, q_count} !== 3'b0_00) begin miss++; $display("FAIL rst_mid_post%0d got we=%0b cnt=%0d exp 0/0", i, rf_we, q_count); end
        end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_lu_idle();
        test_full();
        test_starvation();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
